// File: rtl/rtclock_pps_gen.sv
`default_nettype none
// ============================================================================
// Module      : rtclock_pps_gen
// Description : PPS pulse generator driven by rtclock sec/nsec time. It
//               supports an armed start second, a period in whole seconds
//               and a pulse width in ns.
// Revision    : 1.0 - initial release
// ============================================================================
module rtclock_pps_gen #(
    parameter int C_CLK_TO_NS_RATIO = 8,
    parameter int C_PERIOD_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           sec,
    input  logic [29:0]           nsec,
    input  logic                  en,
    input  logic                  start_valid,
    input  logic [47:0]           start_sec,
    input  logic [C_PERIOD_W-1:0] period_sec,
    input  logic [29:0]           width_ns,
    output logic                  pps,
    output logic [47:0]           pps_sec,
    output logic [31:0]           pps_count,
    output logic                  armed,
    output logic                  err_missed,
    output logic                  err_overlap
);

    localparam logic [29:0] c_wid_max = 30'd999_999_999;
    localparam logic [30:0] c_ratio   = 31'(C_CLK_TO_NS_RATIO);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PULSE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [47:0] r_sec_d;
    logic        r_sec_d_valid;
    logic [47:0] r_next_sec, w_next_sec_nxt;
    logic [30:0] r_cnt, w_cnt_nxt;
    logic        r_pps, w_pps_nxt;
    logic [47:0] r_pps_sec, w_pps_sec_nxt;
    logic [31:0] r_pps_count, w_pps_count_nxt;
    logic        r_err_missed, w_err_missed_nxt;
    logic        r_err_overlap, w_err_overlap_nxt;
    logic        w_restart;

    logic        w_tick;
    logic [47:0] w_per;
    logic [29:0] w_wid;
    logic [47:0] w_sched;
    logic        w_sec_eq;
    logic        w_sec_gt;
    logic        w_cnt_done;
    logic        w_unused_nsec;

    // nsec is carried for context only; second boundaries come from sec.
    assign w_unused_nsec = &{1'b0, nsec};

    // A tick is any change of sec, so time-set jumps in either direction count.
    assign w_tick     = r_sec_d_valid & (sec != r_sec_d);
    assign w_per      = (period_sec == '0) ? 48'd1 : 48'(period_sec);
    assign w_wid      = (width_ns > c_wid_max) ? c_wid_max : width_ns;
    assign w_sched    = sec + w_per;
    assign w_sec_eq   = (sec == r_next_sec);
    assign w_sec_gt   = (sec > r_next_sec);
    assign w_cnt_done = (r_cnt >= {1'b0, w_wid});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_d       <= '0;
            r_sec_d_valid <= 1'b0;
        end else begin
            r_sec_d       <= sec;
            r_sec_d_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_next_sec    <= '0;
            r_cnt         <= '0;
            r_pps         <= 1'b0;
            r_pps_sec     <= '0;
            r_pps_count   <= '0;
            r_err_missed  <= 1'b0;
            r_err_overlap <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_next_sec    <= w_next_sec_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pps         <= w_pps_nxt;
            r_pps_sec     <= w_pps_sec_nxt;
            r_pps_count   <= w_pps_count_nxt;
            r_err_missed  <= w_err_missed_nxt;
            r_err_overlap <= w_err_overlap_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_next_sec_nxt    = r_next_sec;
        w_cnt_nxt         = r_cnt;
        w_pps_nxt         = r_pps;
        w_pps_sec_nxt     = r_pps_sec;
        w_pps_count_nxt   = r_pps_count;
        w_err_missed_nxt  = r_err_missed;
        w_err_overlap_nxt = r_err_overlap;
        w_restart         = 1'b0;

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_pps_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_pps_nxt = 1'b0;
                    if (start_valid) begin
                        w_state_nxt    = S_ARMED;
                        w_next_sec_nxt = start_sec;
                    end
                end
                S_ARMED, S_PULSE: begin
                    // A start strobe masks any tick in the same cycle.
                    if (start_valid) begin
                        w_next_sec_nxt = start_sec;
                    end else if (w_tick && w_sec_eq) begin
                        w_restart       = 1'b1;
                        w_state_nxt     = S_PULSE;
                        w_pps_nxt       = 1'b1;
                        w_cnt_nxt       = c_ratio;
                        w_pps_sec_nxt   = sec;
                        w_pps_count_nxt = r_pps_count + 32'd1;
                        w_next_sec_nxt  = w_sched;
                        if (r_state == S_PULSE) begin
                            w_err_overlap_nxt = 1'b1;
                        end
                    end else if (w_tick && w_sec_gt) begin
                        w_err_missed_nxt = 1'b1;
                        w_next_sec_nxt   = w_sched;
                    end

                    // Width timing runs unless the pulse was just restarted.
                    if (r_state == S_PULSE && !w_restart) begin
                        w_cnt_nxt = r_cnt + c_ratio;
                        if (w_cnt_done) begin
                            w_pps_nxt   = 1'b0;
                            w_state_nxt = S_ARMED;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_pps_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign pps         = r_pps;
    assign pps_sec     = r_pps_sec;
    assign pps_count   = r_pps_count;
    assign armed       = (r_state != S_IDLE);
    assign err_missed  = r_err_missed;
    assign err_overlap = r_err_overlap;

endmodule
`default_nettype wire
